store_buffer: RTL and testbench
===============================

// Module: store_buffer
// PURPOSE
//   Word-wide posted-write buffer between the pipelined core's memory stage and data memory.
//   Captures each store issued in M (MemWriteM, ALUResult, WriteData) into a FIFO.
//   Drains the FIFO to the memory write port under a valid/ready handshake.
//   Returns load data to the core, forwarding from the youngest pending store to the same word.
// PARAMETERS
//   DEPTH  4   number of pending store entries (power of two, >=2)
//   AW     32  address width; word index = addr[AW-1:2]
//   DW     32  data width
// PORTS
//   clk         in   1            rising-edge clock
//   reset       in   1            asynchronous, active-high; clears all state
//   MemWriteM   in   1            store in M this cycle
//   LoadM       in   1            load in M this cycle (never high together with MemWriteM)
//   ALUResult   in   AW           M-stage address
//   WriteData   in   DW           M-stage store data
//   ReadData    out  DW           load data to core (combinational)
//   BufFull     out  1            count==DEPTH; hazard unit stalls M on this
//   BufEmpty    out  1            count==0; used for fences and halt
//   Overflow    out  1            sticky: a store was dropped
//   mem_wvalid  out  1            head entry valid
//   mem_waddr   out  AW           head entry address, addr[1:0] forced to 0
//   mem_wdata   out  DW           head entry data
//   mem_wready  in   1            memory accepts head this cycle
//   mem_raddr   out  AW           async read address, equal to ALUResult
//   mem_rdata   in   DW           async read data
// BEHAVIOUR
//   - State: circular array of DEPTH {addr,data}; head/tail pointers wrap modulo DEPTH.
//     count is clog2(DEPTH)+1 bits.
//   - Reset (async): head=tail=count=0, Overflow=0, mem_wvalid=0, BufEmpty=1, BufFull=0.
//     Reset mid-drain discards all pending entries with no partial write.
//     mem_wvalid drops in the same cycle as reset assertion.
//   - pop  = mem_wvalid & mem_wready.
//   - push = MemWriteM & (count<DEPTH | pop).
//   - Push writes entry[tail] and increments tail. Pop increments head.
//   - count += push - pop. Simultaneous push and pop leaves count unchanged, including at full.
//   - Dropped store: MemWriteM & full & !pop. The store is discarded, Overflow is set
//     (sticky until reset), and pointers and count are unchanged.
//   - Latency: a store pushed at edge t appears on mem_w* from t+1 if the buffer was empty.
//     Otherwise it appears after all older entries pop. Order is strict FIFO.
//   - mem_w* are driven only from entry[head], registered state, and stay stable while
//     mem_wvalid & !mem_wready. mem_wvalid = (count!=0).
//   - Forwarding is combinational while LoadM is high.
//     Compare ALUResult[AW-1:2] against all valid entries.
//     ReadData = data of the youngest matching entry, nearest tail.
//     With no match, ReadData = mem_rdata.
//     An entry popping in the current cycle still counts as valid for forwarding.
//     A store pushed in the current cycle is never forwarded, because LoadM and MemWriteM
//     are exclusive.
//   - When LoadM=0, ReadData = mem_rdata. No state changes on loads.
//   - Sub-word stores are out of scope: every store writes a full word and addr[1:0] is ignored.
// TESTING
//   1. Store A=0x100/0xDEAD with mem_wready=1: mem_wvalid=1 next cycle, addr 0x100,
//      data 0xDEAD, popped; BufEmpty=1 after.
//   2. mem_wready=0 with 4 stores: BufFull=1. A 5th store gives Overflow=1, count stays 4,
//      and the 5th data is never written.
//   3. At full, push and pop in the same cycle: count stays 4, no Overflow, new entry is at
//      the tail, drain order is preserved.
//   4. Stores 0x200<-1 then 0x200<-2 held, load 0x202: ReadData=2.
//      Load 0x204: ReadData=mem_rdata.
//   5. Load to the same address as the popping head: ReadData equals the head data on that cycle.
//   6. Assert reset with 3 pending entries: mem_wvalid=0 immediately, count=0, Overflow=0,
//      and no further memory writes occur.

Source files
------------

// File: rtl/store_buffer.sv
// Posted-write store buffer: FIFO of word stores drained to memory under valid/ready,
// with combinational load forwarding from the youngest pending store to the same word.
module store_buffer #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned AW    = 32,
  parameter int unsigned DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          MemWriteM,
  input  logic          LoadM,
  input  logic [AW-1:0] ALUResult,
  input  logic [DW-1:0] WriteData,
  output logic [DW-1:0] ReadData,
  output logic          BufFull,
  output logic          BufEmpty,
  output logic          Overflow,
  output logic          mem_wvalid,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_wready,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata
);

  localparam int unsigned PW   = $clog2(DEPTH);
  localparam logic [PW:0] FULL = (PW+1)'(DEPTH);

  logic [AW-3:0] r_waddr [DEPTH];
  logic [DW-1:0] r_wdata [DEPTH];
  logic [PW-1:0] r_head;
  logic [PW-1:0] r_tail;
  logic [PW:0]   r_count;
  logic          r_overflow;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [DW-1:0] w_rdata;
  logic [PW:0]   w_age;
  logic [PW-1:0] w_idx;

  assign w_full = (r_count == FULL);
  assign w_pop  = mem_wvalid & mem_wready;
  // A pop in the same cycle frees a slot, so a push at full is still accepted.
  assign w_push = MemWriteM & (~w_full | w_pop);
  assign w_drop = MemWriteM & w_full & ~w_pop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_head     <= '0;
      r_tail     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_tail <= r_tail + 1'b1;
      if (w_pop)  r_head <= r_head + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (w_drop) r_overflow <= 1'b1;
    end
  end

  // Entry storage needs no reset: validity is tracked by head/count alone.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_waddr[r_tail] <= ALUResult[AW-1:2];
      r_wdata[r_tail] <= WriteData;
    end
  end

  // Walk entries oldest to youngest so the last match (nearest tail) wins.
  always_comb begin
    w_rdata = mem_rdata;
    w_age   = '0;
    w_idx   = '0;
    if (LoadM) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        w_age = (PW+1)'(i);
        w_idx = r_head + w_age[PW-1:0];
        if ((w_age < r_count) && (r_waddr[w_idx] == ALUResult[AW-1:2]))
          w_rdata = r_wdata[w_idx];
      end
    end
  end

  assign ReadData   = w_rdata;
  assign BufFull    = w_full;
  assign BufEmpty   = (r_count == '0);
  assign Overflow   = r_overflow;
  assign mem_wvalid = (r_count != '0);
  assign mem_waddr  = {r_waddr[r_head], 2'b00};
  assign mem_wdata  = r_wdata[r_head];
  assign mem_raddr  = ALUResult;

endmodule

// File: tb/tb_store_buffer.sv
// Directed self-checking bench for store_buffer: drain, overflow, push/pop at full,
// forwarding (including from a popping head) and asynchronous reset mid-drain.
module tb_store_buffer;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned AW    = 32;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          MemWriteM;
  logic          LoadM;
  logic [AW-1:0] ALUResult;
  logic [DW-1:0] WriteData;
  logic [DW-1:0] ReadData;
  logic          BufFull;
  logic          BufEmpty;
  logic          Overflow;
  logic          mem_wvalid;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          mem_wready;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;

  int errors = 0;
  int checks = 0;

  logic [AW-1:0] wlog_a[$];
  logic [DW-1:0] wlog_d[$];

  store_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .MemWriteM(MemWriteM), .LoadM(LoadM),
    .ALUResult(ALUResult), .WriteData(WriteData), .ReadData(ReadData),
    .BufFull(BufFull), .BufEmpty(BufEmpty), .Overflow(Overflow),
    .mem_wvalid(mem_wvalid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .mem_wready(mem_wready), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Inputs change only at posedge+1, so the negedge sees the handshake of the coming edge.
  always @(negedge clk) begin
    if (!reset && mem_wvalid && mem_wready) begin
      wlog_a.push_back(mem_waddr);
      wlog_d.push_back(mem_wdata);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d);
    MemWriteM = 1'b1;
    ALUResult = a;
    WriteData = d;
    tick();
    MemWriteM = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    MemWriteM = 1'b0;
    LoadM = 1'b0;
    mem_wready = 1'b0;
    wlog_a.delete();
    wlog_d.delete();
  endtask

  task automatic test_reset();
    reset = 1'b1; MemWriteM = 1'b0; LoadM = 1'b0; ALUResult = '0; WriteData = '0;
    mem_wready = 1'b0; mem_rdata = '0;
    tick(); tick();
    @(negedge clk);
    checks++; if (BufEmpty !== 1'b1) begin errors++; $display("FAIL reset_empty: got %b expected 1", BufEmpty); end
    checks++; if (BufFull !== 1'b0) begin errors++; $display("FAIL reset_full: got %b expected 0", BufFull); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", Overflow); end
    checks++; if (mem_wvalid !== 1'b0) begin errors++; $display("FAIL reset_wvalid: got %b expected 0", mem_wvalid); end
    tick();
    reset = 1'b0;
  endtask

  task automatic test_single_store();
    wlog_a.delete(); wlog_d.delete();
    mem_wready = 1'b1;
    store(32'h100, 32'hDEAD);
    checks++; if (mem_wvalid !== 1'b1) begin errors++; $display("FAIL single_wvalid: got %b expected 1", mem_wvalid); end
    checks++; if (mem_waddr !== 32'h100) begin errors++; $display("FAIL single_waddr: got %h expected 00000100", mem_waddr); end
    checks++; if (mem_wdata !== 32'hDEAD) begin errors++; $display("FAIL single_wdata: got %h expected 0000dead", mem_wdata); end
    tick();
    @(negedge clk);
    checks++; if (BufEmpty !== 1'b1) begin errors++; $display("FAIL single_empty_after: got %b expected 1", BufEmpty); end
    checks++; if (wlog_a.size() != 1) begin errors++; $display("FAIL single_nwrites: got %0d expected 1", wlog_a.size()); end
    else begin
      checks++; if (wlog_d[0] !== 32'hDEAD) begin errors++; $display("FAIL single_logdata: got %h expected 0000dead", wlog_d[0]); end
    end
    mem_wready = 1'b0;
    tick();
  endtask

  task automatic test_overflow();
    wlog_a.delete(); wlog_d.delete();
    mem_wready = 1'b0;
    for (int i = 0; i < 4; i++) store(32'h10 + 32'(4*i) + 32'h3, 32'(i + 1));
    @(negedge clk);
    checks++; if (BufFull !== 1'b1) begin errors++; $display("FAIL ovf_full: got %b expected 1", BufFull); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL ovf_early: got %b expected 0", Overflow); end
    checks++; if (mem_waddr !== 32'h10) begin errors++; $display("FAIL ovf_waddr_align: got %h expected 00000010", mem_waddr); end
    tick();
    store(32'h40, 32'h55);
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", Overflow); end
    checks++; if (BufFull !== 1'b1) begin errors++; $display("FAIL ovf_still_full: got %b expected 1", BufFull); end
    mem_wready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checks++; if (BufEmpty !== 1'b1) begin errors++; $display("FAIL ovf_drained: got %b expected 1", BufEmpty); end
    checks++; if (Overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", Overflow); end
    checks++; if (wlog_d.size() != 4) begin errors++; $display("FAIL ovf_nwrites: got %0d expected 4", wlog_d.size()); end
    else begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (wlog_d[i] !== 32'(i + 1)) begin errors++; $display("FAIL ovf_order[%0d]: got %h expected %h", i, wlog_d[i], 32'(i + 1)); end
        checks++; if (wlog_a[i] !== 32'h10 + 32'(4*i)) begin errors++; $display("FAIL ovf_addr[%0d]: got %h expected %h", i, wlog_a[i], 32'h10 + 32'(4*i)); end
      end
    end
    mem_wready = 1'b0;
    tick();
  endtask

  task automatic test_reset_mid_drain();
    mem_wready = 1'b0;
    store(32'h500, 32'hA1); store(32'h504, 32'hA2); store(32'h508, 32'hA3);
    checks++; if (mem_wvalid !== 1'b1) begin errors++; $display("FAIL rst_pre_wvalid: got %b expected 1", mem_wvalid); end
    #1 reset = 1'b1;
    #1;
    checks++; if (mem_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid_now: got %b expected 0", mem_wvalid); end
    checks++; if (BufEmpty !== 1'b1) begin errors++; $display("FAIL rst_empty: got %b expected 1", BufEmpty); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL rst_ovf_clr: got %b expected 0", Overflow); end
    wlog_a.delete(); wlog_d.delete();
    mem_wready = 1'b1;
    tick();
    reset = 1'b0;
    repeat (3) tick();
    checks++; if (wlog_d.size() != 0) begin errors++; $display("FAIL rst_no_writes: got %0d expected 0", wlog_d.size()); end
    checks++; if (mem_wvalid !== 1'b0) begin errors++; $display("FAIL rst_wvalid_after: got %b expected 0", mem_wvalid); end
    mem_wready = 1'b0;
    for (int i = 0; i < 3; i++) store(32'h600 + 32'(4*i), 32'(i));
    checks++; if (BufFull !== 1'b0) begin errors++; $display("FAIL rst_count3: got %b expected 0", BufFull); end
    store(32'h60C, 32'h3);
    checks++; if (BufFull !== 1'b1) begin errors++; $display("FAIL rst_count4: got %b expected 1", BufFull); end
  endtask

  task automatic test_full_push_pop();
    do_reset();
    for (int i = 0; i < 4; i++) store(32'hA0 + 32'(4*i), 32'h11 + 32'(i));
    MemWriteM = 1'b1; ALUResult = 32'hB0; WriteData = 32'h15; mem_wready = 1'b1;
    tick();
    MemWriteM = 1'b0; mem_wready = 1'b0;
    checks++; if (BufFull !== 1'b1) begin errors++; $display("FAIL fpp_full: got %b expected 1", BufFull); end
    checks++; if (Overflow !== 1'b0) begin errors++; $display("FAIL fpp_ovf: got %b expected 0", Overflow); end
    checks++; if (mem_wdata !== 32'h12) begin errors++; $display("FAIL fpp_head: got %h expected 00000012", mem_wdata); end
    LoadM = 1'b1; ALUResult = 32'hB0; mem_rdata = 32'h1234;
    #1;
    checks++; if (ReadData !== 32'h15) begin errors++; $display("FAIL fpp_fwd_wrapped: got %h expected 00000015", ReadData); end
    ALUResult = 32'hA0;
    #1;
    checks++; if (ReadData !== 32'h1234) begin errors++; $display("FAIL fpp_fwd_popped: got %h expected 00001234", ReadData); end
    LoadM = 1'b0;
    mem_wready = 1'b1;
    repeat (4) tick();
    @(negedge clk);
    checks++; if (BufEmpty !== 1'b1) begin errors++; $display("FAIL fpp_drained: got %b expected 1", BufEmpty); end
    checks++; if (wlog_d.size() != 5) begin errors++; $display("FAIL fpp_nwrites: got %0d expected 5", wlog_d.size()); end
    else begin
      for (int i = 0; i < 5; i++) begin
        checks++; if (wlog_d[i] !== 32'h11 + 32'(i)) begin errors++; $display("FAIL fpp_order[%0d]: got %h expected %h", i, wlog_d[i], 32'h11 + 32'(i)); end
      end
      checks++; if (wlog_a[4] !== 32'hB0) begin errors++; $display("FAIL fpp_tail_addr: got %h expected 000000b0", wlog_a[4]); end
    end
    mem_wready = 1'b0;
    tick();
  endtask

  task automatic test_forward();
    do_reset();
    store(32'h200, 32'h1);
    store(32'h200, 32'h2);
    mem_rdata = 32'hBEEF;
    LoadM = 1'b1; ALUResult = 32'h202;
    #1;
    checks++; if (ReadData !== 32'h2) begin errors++; $display("FAIL fwd_youngest: got %h expected 00000002", ReadData); end
    checks++; if (mem_raddr !== 32'h202) begin errors++; $display("FAIL fwd_raddr: got %h expected 00000202", mem_raddr); end
    ALUResult = 32'h204;
    #1;
    checks++; if (ReadData !== 32'hBEEF) begin errors++; $display("FAIL fwd_nomatch: got %h expected 0000beef", ReadData); end
    LoadM = 1'b0; ALUResult = 32'h200;
    #1;
    checks++; if (ReadData !== 32'hBEEF) begin errors++; $display("FAIL fwd_noload: got %h expected 0000beef", ReadData); end
    LoadM = 1'b1;
    tick();
    LoadM = 1'b0;
    checks++; if (mem_wdata !== 32'h1 || BufEmpty !== 1'b0) begin errors++; $display("FAIL fwd_load_nostate: got head=%h empty=%b expected head=00000001 empty=0", mem_wdata, BufEmpty); end
  endtask

  task automatic test_pop_forward();
    do_reset();
    store(32'h300, 32'h77);
    store(32'h304, 32'h88);
    mem_rdata = 32'hCAFE;
    LoadM = 1'b1; ALUResult = 32'h300; mem_wready = 1'b1;
    #1;
    checks++; if (ReadData !== 32'h77) begin errors++; $display("FAIL popfwd_head: got %h expected 00000077", ReadData); end
    tick();
    mem_wready = 1'b0;
    #1;
    checks++; if (ReadData !== 32'hCAFE) begin errors++; $display("FAIL popfwd_gone: got %h expected 0000cafe", ReadData); end
    ALUResult = 32'h304;
    #1;
    checks++; if (ReadData !== 32'h88) begin errors++; $display("FAIL popfwd_next: got %h expected 00000088", ReadData); end
    LoadM = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_overflow();
    test_reset_mid_drain();
    test_full_push_pop();
    test_forward();
    test_pop_forward();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
